// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu
//   MEM-stage load/store unit. Takes the access held in the EX/MEM register,
//   runs it on a req/gnt/rvalid data bus and returns the lane-selected,
//   sign/zero-extended load result to MEM/WB. lsu_stall holds the pipeline
//   until the access completes; misaligned or illegal accesses raise a
//   one-cycle lsu_fault instead of touching the bus.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   me_mem_read     load in MEM stage (wins over me_mem_write)
//   me_mem_write    store in MEM stage
//   me_funct3       RV32I access size/sign
//   me_addr         effective byte address
//   me_wdata        store data, LSB aligned
//   me_mem_data     registered, formatted load result
//   lsu_stall       pipeline hold
//   lsu_fault       1-cycle fault pulse
//   dbus_*          data bus request side / response side
// -----------------------------------------------------------------------------
module mem_lsu #(
  parameter logic [31:0] RESET_DATA = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        me_mem_read,
  input  logic        me_mem_write,
  input  logic [2:0]  me_funct3,
  input  logic [31:0] me_addr,
  input  logic [31:0] me_wdata,
  output logic [31:0] me_mem_data,
  output logic        lsu_stall,
  output logic        lsu_fault,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  logic        is_load_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        acc_valid;
  logic        legal_f3;
  logic        misaligned;
  logic        acc_fault;
  logic        start;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_fmt;

  // Access decode in IDLE; a set read masks a simultaneous write.
  always_comb begin
    acc_valid = me_mem_read | me_mem_write;
    legal_f3  = 1'b0;
    if (me_mem_read) begin
      case (me_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
        default:                                legal_f3 = 1'b0;
      endcase
    end else begin
      case (me_funct3)
        3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
        default:                legal_f3 = 1'b0;
      endcase
    end
    misaligned = ((me_funct3[1:0] == 2'b01) && me_addr[0]) ||
                 ((me_funct3[1:0] == 2'b10) && (me_addr[1:0] != 2'b00));
    acc_fault  = acc_valid && (!legal_f3 || misaligned);
    start      = (state == S_IDLE) && acc_valid && !acc_fault;
  end

  // Stall is combinational so the issuing cycle already holds the pipeline;
  // forced low while reset is asserted.
  always_comb begin
    lsu_stall = rst && (start || (state == S_REQ) || (state == S_WAIT));
  end

  // Store lane placement; loads always request the full word.
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = me_wdata;
    if (!me_mem_read) begin
      case (me_funct3[1:0])
        2'b00: begin
          be_n    = 4'b0001 << me_addr[1:0];
          wdata_n = {4{me_wdata[7:0]}};
        end
        2'b01: begin
          be_n    = 4'b0011 << me_addr[1:0];
          wdata_n = {2{me_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load lane select and extension, driven by the latched access.
  always_comb begin
    case (off_q)
      2'd0:    lane_b = dbus_rdata[7:0];
      2'd1:    lane_b = dbus_rdata[15:8];
      2'd2:    lane_b = dbus_rdata[23:16];
      default: lane_b = dbus_rdata[31:24];
    endcase
    lane_h = off_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (f3_q)
      3'b000:  load_fmt = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_fmt = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_fmt = {24'h0, lane_b};
      3'b101:  load_fmt = {16'h0, lane_h};
      default: load_fmt = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      is_load_q   <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      me_mem_data <= RESET_DATA;
      lsu_fault   <= 1'b0;
      dbus_req    <= 1'b0;
      dbus_we     <= 1'b0;
      dbus_be     <= '0;
      dbus_addr   <= '0;
      dbus_wdata  <= '0;
    end else begin
      lsu_fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            is_load_q  <= me_mem_read;
            f3_q       <= me_funct3;
            off_q      <= me_addr[1:0];
            dbus_req   <= 1'b1;
            dbus_we    <= !me_mem_read;
            dbus_be    <= be_n;
            dbus_addr  <= {me_addr[31:2], 2'b00};
            dbus_wdata <= wdata_n;
            state      <= S_REQ;
          end else if (acc_fault) begin
            lsu_fault <= 1'b1;
            if (me_mem_read) me_mem_data <= RESET_DATA;
          end
        end
        S_REQ: begin
          if (dbus_gnt) begin
            dbus_req <= 1'b0;
            if (!is_load_q) begin
              state <= S_DONE;
            end else if (dbus_rvalid) begin
              // Zero-latency response arrives together with the grant.
              me_mem_data <= load_fmt;
              state       <= S_DONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dbus_rvalid) begin
            me_mem_data <= load_fmt;
            state       <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_lsu
//   Scoreboarded bench for mem_lsu. The driver issues accesses and pushes the
//   expected outcome (computed with plain arithmetic from the access rules);
//   a bus responder plays the slave with programmable gnt/rvalid delays; a
//   monitor pops and compares on each fault pulse or access completion.
// -----------------------------------------------------------------------------
module tb_mem_lsu;

  localparam logic [31:0] TB_RESET_DATA = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        me_mem_read = 1'b0;
  logic        me_mem_write = 1'b0;
  logic [2:0]  me_funct3 = '0;
  logic [31:0] me_addr = '0;
  logic [31:0] me_wdata = '0;
  logic [31:0] me_mem_data;
  logic        lsu_stall;
  logic        lsu_fault;
  logic        dbus_req;
  logic        dbus_we;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt = 1'b0;
  logic        dbus_rvalid = 1'b0;
  logic [31:0] dbus_rdata = '0;

  mem_lsu #(.RESET_DATA(TB_RESET_DATA)) dut (
    .clk(clk), .rst(rst),
    .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
    .me_funct3(me_funct3), .me_addr(me_addr), .me_wdata(me_wdata),
    .me_mem_data(me_mem_data), .lsu_stall(lsu_stall), .lsu_fault(lsu_fault),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fault;
    bit          abort;
    bit          we;
    logic [31:0] addr;
    logic [31:0] be;
    logic [31:0] wdata;
    logic [31:0] data;
    int          stall;
    int          reqc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          passed = 0;
  logic [31:0] model_data = TB_RESET_DATA;
  int          gnt_wait = 0;
  int          rv_wait = 1;
  logic [31:0] resp_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
  endtask

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input int off, input logic [31:0] data);
    logic [31:0] v;
    logic [31:0] r;
    v = data >> (off * 8);
    case (f3)
      3'd0: begin r = v % 256;   if (r >= 128)   r = r - 256;   end
      3'd1: begin r = v % 65536; if (r >= 32768) r = r - 65536; end
      3'd4: r = v % 256;
      3'd5: r = v % 65536;
      default: r = data;
    endcase
    return r;
  endfunction

  task automatic clear_inputs();
    me_mem_read  = 1'b0;
    me_mem_write = 1'b0;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with it idle.
  task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int gw, input int rw, input logic [31:0] rdat);
    exp_t e;
    int   sz;
    int   off;
    bit   legal;
    int   n;
    if (!rd && !wr) begin
      @(posedge clk); #1;
      return;
    end
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = addr % 4;
    legal = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    legal = legal && (addr % sz == 0);
    e.fault = !legal;
    e.abort = 1'b0;
    e.we    = !rd;
    e.addr  = addr - off;
    e.be    = rd ? 32'd15 : (((32'd1 << sz) - 1) << off);
    e.wdata = (sz == 1) ? (wd % 256) * 32'h01010101 :
              (sz == 2) ? (wd % 65536) * 32'h00010001 : wd;
    e.stall = 2 + gw + (rd ? rw : 0);
    e.reqc  = gw + 1;
    if (!legal) begin
      if (rd) model_data = TB_RESET_DATA;
    end else if (rd) begin
      model_data = fmt_load(f3, off, rdat);
    end
    e.data = model_data;
    q.push_back(e);
    gnt_wait     = gw;
    rv_wait      = rw;
    resp_data    = rdat;
    me_mem_read  = rd;
    me_mem_write = wr;
    me_funct3    = f3;
    me_addr      = addr;
    me_wdata     = wd;
    if (!legal) begin
      @(posedge clk); #1;
      clear_inputs();
      me_addr = $urandom;
      return;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (lsu_stall && n < 100);
    if (lsu_stall) chk("done_timeout", {31'b0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    me_addr = $urandom;
  endtask

  // Bus slave: grant after gnt_wait cycles, read data rv_wait cycles after
  // the grant (0 = same cycle as grant); garbage on rdata otherwise.
  initial begin
    forever begin
      @(posedge clk); #1;
      dbus_rdata = $urandom;
      if (dbus_req) begin
        automatic int  gw  = gnt_wait;
        automatic int  rw  = rv_wait;
        automatic bit  ld  = !dbus_we;
        for (int i = 0; i < gw; i++) begin
          @(posedge clk); #1;
          dbus_rdata = $urandom;
        end
        dbus_gnt = 1'b1;
        if (ld && rw == 0) begin
          dbus_rvalid = 1'b1;
          dbus_rdata  = resp_data;
        end
        @(posedge clk); #1;
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
        dbus_rdata  = $urandom;
        if (ld && rw > 0) begin
          for (int i = 1; i < rw; i++) begin
            @(posedge clk); #1;
            dbus_rdata = $urandom;
          end
          dbus_rvalid = 1'b1;
          dbus_rdata  = resp_data;
          @(posedge clk); #1;
          dbus_rvalid = 1'b0;
          dbus_rdata  = $urandom;
        end
      end
    end
  end

  // Monitor: compare on fault pulses and at access completion.
  initial begin
    bit          busy = 1'b0;
    bit          saw_req = 1'b0;
    int          scnt = 0;
    int          rcnt = 0;
    logic [31:0] b_addr = '0;
    logic [3:0]  b_be = '0;
    logic        b_we = 1'b0;
    logic [31:0] b_wdata = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (lsu_fault) begin
        if (q.size() == 0) chk("unexpected_fault", q.size(), 1);
        else begin
          e = q.pop_front();
          chk("fault_pulse", {31'b0, lsu_fault}, {31'b0, e.fault});
          chk("fault_data", me_mem_data, e.data);
          chk("fault_no_req", {31'b0, dbus_req}, 32'd0);
        end
      end
      if (lsu_stall) begin
        if (!busy) begin
          busy = 1'b1; scnt = 0; rcnt = 0; saw_req = 1'b0;
        end
        scnt++;
        if (dbus_req) begin
          rcnt++;
          if (!saw_req) begin
            saw_req = 1'b1;
            b_addr = dbus_addr; b_be = dbus_be; b_we = dbus_we; b_wdata = dbus_wdata;
          end
        end
      end else if (busy) begin
        busy = 1'b0;
        if (q.size() == 0) chk("unexpected_done", q.size(), 1);
        else begin
          e = q.pop_front();
          if (e.abort) begin
            chk("abort_data", me_mem_data, e.data);
            chk("abort_req", {31'b0, dbus_req}, 32'd0);
          end else begin
            chk("done_fault", {31'b0, e.fault}, 32'd0);
            chk("stall_cycles", scnt, e.stall);
            chk("req_cycles", rcnt, e.reqc);
            chk("bus_addr", b_addr, e.addr);
            chk("bus_be", {28'b0, b_be}, e.be);
            chk("bus_we", {31'b0, b_we}, {31'b0, e.we});
            if (e.we) chk("bus_wdata", b_wdata, e.wdata);
            chk("mem_data", me_mem_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    int   n;
    #12;
    chk("rst_mem_data", me_mem_data, TB_RESET_DATA);
    chk("rst_req", {31'b0, dbus_req}, 32'd0);
    chk("rst_fault", {31'b0, lsu_fault}, 32'd0);
    chk("rst_stall", {31'b0, lsu_stall}, 32'd0);
    chk("rst_be", {28'b0, dbus_be}, 32'd0);
    chk("rst_addr", dbus_addr, 32'd0);
    chk("rst_wdata", dbus_wdata, 32'd0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    issue(1, 0, 3'd2, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
    issue(1, 0, 3'd0, 32'h103, 32'h0, 0, 1, 32'h80112233);
    issue(1, 0, 3'd4, 32'h103, 32'h0, 1, 2, 32'h80112233);
    issue(1, 0, 3'd5, 32'h102, 32'h0, 0, 1, 32'h80112233);
    issue(0, 1, 3'd1, 32'h206, 32'h1234ABCD, 3, 0, 32'h0);
    issue(1, 0, 3'd2, 32'h102, 32'h0, 0, 1, 32'h55555555);
    issue(0, 1, 3'd2, 32'h101, 32'hCAFEF00D, 0, 0, 32'h0);
    issue(1, 0, 3'd1, 32'h010, 32'h0, 0, 0, 32'h00007FFF);
    issue(1, 0, 3'd2, 32'h014, 32'h0, 0, 0, 32'hA5A50F0F);
    issue(1, 1, 3'd0, 32'h021, 32'h000000EE, 0, 1, 32'h0000C300);
    issue(1, 0, 3'd3, 32'h030, 32'h0, 0, 1, 32'h0);
    issue(0, 1, 3'd4, 32'h030, 32'h0, 0, 0, 32'h0);

    // Reset during WAIT, late response after release must be ignored
    e.fault = 1'b0; e.abort = 1'b1; e.we = 1'b0; e.addr = 32'h300; e.be = 32'd15;
    e.wdata = '0; e.data = TB_RESET_DATA; e.stall = 0; e.reqc = 0;
    model_data = TB_RESET_DATA;
    q.push_back(e);
    gnt_wait = 0; rv_wait = 6; resp_data = 32'h12345678;
    me_mem_read = 1'b1; me_funct3 = 3'd2; me_addr = 32'h300;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    #1;
    chk("midrst_req", {31'b0, dbus_req}, 32'd0);
    chk("midrst_stall", {31'b0, lsu_stall}, 32'd0);
    chk("midrst_data", me_mem_data, TB_RESET_DATA);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("late_rv_data", me_mem_data, TB_RESET_DATA);
    chk("late_rv_req", {31'b0, dbus_req}, 32'd0);
    chk("late_rv_stall", {31'b0, lsu_stall}, 32'd0);
    chk("late_rv_fault", {31'b0, lsu_fault}, 32'd0);

    // Randomized accesses
    for (int i = 0; i < 80; i++) begin
      automatic bit          rd = 1'($urandom_range(0, 1));
      automatic bit          wr = 1'($urandom_range(0, 1));
      automatic logic [2:0]  f3 = 3'($urandom_range(0, 7));
      automatic logic [31:0] ad = $urandom;
      automatic logic [31:0] wd = $urandom;
      automatic logic [31:0] rdv = $urandom;
      if (!rd && !wr && i % 2 == 0) rd = 1'b1;
      issue(rd, wr, f3, ad, wd, $urandom_range(0, 3), $urandom_range(0, 3), rdv);
    end

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) chk("queue_drain", q.size(), 0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
